// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic pipe unit: operation encodings and
// the two-state output handshake.
package logic_unit_pkg;

   typedef enum logic [2:0] {
      OP_AND   = 3'b000,
      OP_XOR   = 3'b001,
      OP_OR    = 3'b010,
      OP_NOT_B = 3'b011,
      OP_NAND  = 3'b100,
      OP_NOR   = 3'b101,
      OP_XNOR  = 3'b110,
      OP_ANDN  = 3'b111
   } logic_op_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } pipe_state_e;

endpackage

// File: rtl/logic_core.sv
// Purely combinational bitwise operation evaluator; no carries between bits.
module logic_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (logic_op_e'(sel))
         OP_AND:   y = a & b;
         OP_XOR:   y = a ^ b;
         OP_OR:    y = a | b;
         OP_NOT_B: y = ~b;
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_XNOR:  y = ~(a ^ b);
         OP_ANDN:  y = a & ~b;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/logic_pipe_unit.sv
// Single-stage valid/ready logic unit with accumulator chaining, result flags
// and a saturating count of results consumed downstream.
module logic_pipe_unit
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Logic_Sel,
   input  logic             acc_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Logic_Out,
   output logic             zero_flag,
   output logic             parity_flag,
   output logic [CNT_W-1:0] op_count
);

   pipe_state_e      state_reg;
   pipe_state_e      state_next;
   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] acc_reg;
   logic             zero_reg;
   logic             parity_reg;
   logic [CNT_W-1:0] count_reg;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_y;
   logic             accept;
   logic             drain;

   assign out_valid = (state_reg == ST_FULL);
   // The stage passes through when the held result is leaving this cycle.
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   // The accumulator value seen here is the one before this accept.
   assign core_a = acc_mode ? acc_reg : A;

   logic_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .a  (core_a),
      .b  (B),
      .sel(Logic_Sel),
      .y  (core_y)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_EMPTY: if (accept) state_next = ST_FULL;
         ST_FULL:  if (!accept && out_ready) state_next = ST_EMPTY;
         default:  state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_EMPTY;
      else     state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg    <= '0;
         zero_reg   <= 1'b1;
         parity_reg <= 1'b0;
         acc_reg    <= '0;
      end else if (accept) begin
         out_reg    <= core_y;
         zero_reg   <= (core_y == '0);
         parity_reg <= ^core_y;
         acc_reg    <= core_y;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                            count_reg <= '0;
      else if (drain && (count_reg != '1)) count_reg <= count_reg + CNT_W'(1);
   end

   assign Logic_Out   = out_reg;
   assign zero_flag   = zero_reg;
   assign parity_flag = parity_reg;
   assign op_count    = count_reg;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Randomized and directed bench for logic_pipe_unit at WIDTH 8, 1 and 64,
// checked against an in-order result queue model.
module tb_logic_pipe_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Lane 0: WIDTH=8 (plus a CNT_W=4 twin), lane 1: WIDTH=1, lane 2: WIDTH=64
   logic        in_valid_v [3];
   logic        out_ready_v[3];
   logic        acc_v      [3];
   logic [2:0]  sel_v      [3];
   logic [63:0] a_v        [3];
   logic [63:0] b_v        [3];

   logic [7:0]  out8,  out8c;
   logic [0:0]  out1;
   logic [63:0] out64;
   logic [15:0] cnt8, cnt1, cnt64;
   logic [3:0]  cnt4;
   logic rdy8, rdy1, rdy64, rdy8c;
   logic vld8, vld1, vld64, vld8c;
   logic zf8, zf1, zf64, zf8c;
   logic pf8, pf1, pf64, pf8c;

   logic [63:0] o_out  [3];
   logic [15:0] o_cnt  [3];
   logic        o_ready[3];
   logic        o_valid[3];
   logic        o_zero [3];
   logic        o_par  [3];

   assign o_out[0] = {56'b0, out8};
   assign o_out[1] = {63'b0, out1};
   assign o_out[2] = out64;
   assign o_cnt[0] = cnt8;   assign o_cnt[1] = cnt1;   assign o_cnt[2] = cnt64;
   assign o_ready[0] = rdy8; assign o_ready[1] = rdy1; assign o_ready[2] = rdy64;
   assign o_valid[0] = vld8; assign o_valid[1] = vld1; assign o_valid[2] = vld64;
   assign o_zero[0] = zf8;   assign o_zero[1] = zf1;   assign o_zero[2] = zf64;
   assign o_par[0] = pf8;    assign o_par[1] = pf1;    assign o_par[2] = pf64;

   logic_pipe_unit #(.WIDTH(8), .CNT_W(16)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(rdy8),
      .A(a_v[0][7:0]), .B(b_v[0][7:0]), .Logic_Sel(sel_v[0]), .acc_mode(acc_v[0]),
      .out_valid(vld8), .out_ready(out_ready_v[0]), .Logic_Out(out8),
      .zero_flag(zf8), .parity_flag(pf8), .op_count(cnt8));

   logic_pipe_unit #(.WIDTH(8), .CNT_W(4)) dut8c (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(rdy8c),
      .A(a_v[0][7:0]), .B(b_v[0][7:0]), .Logic_Sel(sel_v[0]), .acc_mode(acc_v[0]),
      .out_valid(vld8c), .out_ready(out_ready_v[0]), .Logic_Out(out8c),
      .zero_flag(zf8c), .parity_flag(pf8c), .op_count(cnt4));

   logic_pipe_unit #(.WIDTH(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(rdy1),
      .A(a_v[1][0:0]), .B(b_v[1][0:0]), .Logic_Sel(sel_v[1]), .acc_mode(acc_v[1]),
      .out_valid(vld1), .out_ready(out_ready_v[1]), .Logic_Out(out1),
      .zero_flag(zf1), .parity_flag(pf1), .op_count(cnt1));

   logic_pipe_unit #(.WIDTH(64), .CNT_W(16)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(rdy64),
      .A(a_v[2]), .B(b_v[2]), .Logic_Sel(sel_v[2]), .acc_mode(acc_v[2]),
      .out_valid(vld64), .out_ready(out_ready_v[2]), .Logic_Out(out64),
      .zero_flag(zf64), .parity_flag(pf64), .op_count(cnt64));

   // Model: every accepted result leaves exactly once, in order
   logic [63:0] exp_q  [3][$];
   logic [63:0] exp_acc[3];
   int          exp_cnt[3];
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [63:0] lane_mask(int l);
      case (l)
         0:       return 64'hFF;
         1:       return 64'h1;
         default: return '1;
      endcase
   endfunction

   function automatic logic [63:0] ref_op(logic [2:0] sel, logic [63:0] a, logic [63:0] b,
                                          logic [63:0] m);
      logic [63:0] r;
      case (sel)
         3'd0:    r = a & b;
         3'd1:    r = a ^ b;
         3'd2:    r = a | b;
         3'd3:    r = ~b;
         3'd4:    r = ~(a & b);
         3'd5:    r = ~(a | b);
         3'd6:    r = ~(a ^ b);
         default: r = a & ~b;
      endcase
      return r & m;
   endfunction

   task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(int l, bit v, logic [63:0] a, logic [63:0] b, logic [2:0] sel,
                        bit acc, bit rdy);
      in_valid_v[l]  = v;
      a_v[l]         = a & lane_mask(l);
      b_v[l]         = b & lane_mask(l);
      sel_v[l]       = sel;
      acc_v[l]       = acc;
      out_ready_v[l] = rdy;
   endtask

   task automatic clear_model();
      for (int l = 0; l < 3; l++) begin
         exp_q[l].delete();
         exp_acc[l] = '0;
         exp_cnt[l] = 0;
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step();
      bit          exp_rdy[3];
      logic [63:0] r;
      int          sz;
      #1;
      for (int l = 0; l < 3; l++) begin
         exp_rdy[l] = (exp_q[l].size() == 0) || out_ready_v[l];
         check_eq($sformatf("L%0d in_ready", l), 64'(o_ready[l]), 64'(exp_rdy[l]));
      end
      @(posedge clk);
      if (rst) begin
         clear_model();
      end else begin
         for (int l = 0; l < 3; l++) begin
            if (exp_q[l].size() != 0 && out_ready_v[l]) begin
               void'(exp_q[l].pop_front());
               exp_cnt[l]++;
            end
            if (in_valid_v[l] && exp_rdy[l]) begin
               r = ref_op(sel_v[l], acc_v[l] ? exp_acc[l] : a_v[l], b_v[l], lane_mask(l));
               exp_q[l].push_back(r);
               exp_acc[l] = r;
               $display("L%0d accept sel=%0d acc=%0b a=%h b=%h -> %h",
                        l, sel_v[l], acc_v[l], a_v[l], b_v[l], r);
            end
         end
      end
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
         sz = exp_q[l].size();
         check_eq($sformatf("L%0d out_valid", l), 64'(o_valid[l]), 64'(sz != 0));
         if (sz != 0) begin
            check_eq($sformatf("L%0d Logic_Out", l), o_out[l], exp_q[l][0]);
            check_eq($sformatf("L%0d zero_flag", l), 64'(o_zero[l]), 64'(exp_q[l][0] == 0));
            check_eq($sformatf("L%0d parity_flag", l), 64'(o_par[l]), 64'(^exp_q[l][0]));
         end
         check_eq($sformatf("L%0d op_count", l), 64'(o_cnt[l]),
                  64'((exp_cnt[l] > 65535) ? 65535 : exp_cnt[l]));
      end
      check_eq("L0 op_count4", 64'(cnt4), 64'((exp_cnt[0] > 15) ? 15 : exp_cnt[0]));
   endtask

   initial begin
      for (int l = 0; l < 3; l++) drive(l, 0, 0, 0, 3'd0, 0, 1);
      rst = 1'b1;
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int l = 0; l < 3; l++) begin
         check_eq($sformatf("L%0d rst out_valid", l), 64'(o_valid[l]), 64'(0));
         check_eq($sformatf("L%0d rst Logic_Out", l), o_out[l], 64'(0));
         check_eq($sformatf("L%0d rst zero", l), 64'(o_zero[l]), 64'(1));
         check_eq($sformatf("L%0d rst parity", l), 64'(o_par[l]), 64'(0));
         check_eq($sformatf("L%0d rst op_count", l), 64'(o_cnt[l]), 64'(0));
         check_eq($sformatf("L%0d rst in_ready", l), 64'(o_ready[l]), 64'(1));
      end

      // Basic AND
      drive(0, 1, 64'hF0, 64'h3C, 3'b000, 0, 1);
      step();
      check_eq("and F0&3C", o_out[0], 64'h30);
      check_eq("and zero", 64'(zf8), 64'(0));
      check_eq("and parity", 64'(pf8), 64'(0));
      check_eq("and valid", 64'(vld8), 64'(1));

      // Accumulator chain, back to back
      drive(0, 1, 64'h00, 64'h0F, 3'b010, 0, 1);
      step();
      check_eq("chain1", o_out[0], 64'h0F);
      drive(0, 1, 64'h5A, 64'hFF, 3'b001, 1, 1);
      step();
      check_eq("chain2", o_out[0], 64'hF0);
      check_eq("chain2 valid", 64'(vld8), 64'(1));

      // Boundary ops
      drive(0, 1, 64'hAA, 64'hAA, 3'b110, 0, 1);
      step();
      check_eq("xnor AA", o_out[0], 64'hFF);
      check_eq("xnor parity", 64'(pf8), 64'(0));
      drive(0, 1, 64'h5C, 64'h5C, 3'b111, 0, 1);
      step();
      check_eq("andn A=B", o_out[0], 64'h00);
      check_eq("andn zero", 64'(zf8), 64'(1));

      // Backpressure: stall three cycles, then stream from the held accumulator
      drive(0, 1, 64'hC3, 64'h0F, 3'b000, 0, 1);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 64'($urandom), 64'($urandom), 3'($urandom_range(0, 7)), 1, 0);
         step();
         check_eq("bp in_ready", 64'(rdy8), 64'(0));
         check_eq("bp hold", o_out[0], 64'h03);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 64'h00, 64'h01, 3'b001, 1, 1);
         step();
         check_eq("bp resume", o_out[0], (i % 2 == 0) ? 64'h02 : 64'h03);
      end

      // Stream enough drains to saturate the narrow counter
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 64'($urandom), 64'($urandom), 3'($urandom_range(0, 7)), 0, 1);
         step();
      end
      check_eq("cnt4 saturated", 64'(cnt4), 64'hF);

      // Reset while FULL discards the held result and clears the accumulator
      drive(0, 1, 64'hAA, 64'h55, 3'b010, 0, 0);
      step();
      rst = 1'b1;
      drive(0, 1, 64'h12, 64'h34, 3'b010, 0, 1);
      step();
      rst = 1'b0;
      check_eq("rstfull valid", 64'(vld8), 64'(0));
      check_eq("rstfull count", 64'(cnt8), 64'(0));
      check_eq("rstfull count4", 64'(cnt4), 64'(0));
      check_eq("rstfull out", o_out[0], 64'(0));
      drive(0, 1, 64'hFF, 64'h00, 3'b010, 1, 1);
      step();
      check_eq("rstfull acc", o_out[0], 64'h00);

      // Randomized traffic on all lanes
      for (int i = 0; i < 150; i++) begin
         for (int l = 0; l < 3; l++)
            drive(l, $urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0);
         step();
      end
      for (int l = 0; l < 3; l++) drive(l, 0, 0, 0, 3'd0, 0, 1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
